// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: splits the HPS download stream into four ROM regions and keeps
// the core in reset until a complete, correctly sized image is loaded and settled.
// Ports: clk_sys/reset_n; dn_* download port in; user_reset request in;
//        rom_wr/rom_addr/rom_data region writes out; core_reset, busy, load_ok, load_err status out.
module rom_load_sequencer #(
  parameter int ADDR_W     = 17,
  parameter int B1         = 'h0A000,
  parameter int B2         = 'h0C000,
  parameter int B3         = 'h10000,
  parameter int TOTAL      = 'h1C000,
  parameter int SETTLE_CYC = 256
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [24:0]       dn_addr,
  input  logic [7:0]        dn_data,
  input  logic              user_reset,
  output logic [3:0]        rom_wr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic              core_reset,
  output logic              busy,
  output logic              load_ok,
  output logic              load_err
);

  localparam int CW = ADDR_W + 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

  state_t            state_q, state_d;
  logic              dl_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              err_q, err_d;
  logic              ok_d, lerr_d;
  logic              dl_rise, dl_fall, accept, in_range;
  logic [ADDR_W-1:0] a;
  logic [3:0]        wr_d;
  logic [ADDR_W-1:0] off_d;

  assign a        = dn_addr[ADDR_W-1:0];
  assign dl_rise  = dn_download & ~dl_q;
  assign dl_fall  = ~dn_download & dl_q;
  // Writes count only inside a download window that this block saw open;
  // the raw level is used so a write on the opening cycle is kept.
  assign accept   = dn_wr & dn_download & (dl_rise | (state_q == LOAD));
  assign in_range = dn_addr < 25'(TOTAL);
  assign busy     = (state_q == LOAD) | (state_q == SETTLE);

  // Region decode. The last region takes everything below TOTAL, which in_range
  // already guarantees, so TOTAL == 2^ADDR_W needs no special case.
  always_comb begin
    wr_d  = '0;
    off_d = '0;
    if (a < ADDR_W'(B1)) begin
      wr_d  = 4'b0001;
      off_d = a;
    end else if (a < ADDR_W'(B2)) begin
      wr_d  = 4'b0010;
      off_d = a - ADDR_W'(B1);
    end else if (a < ADDR_W'(B3)) begin
      wr_d  = 4'b0100;
      off_d = a - ADDR_W'(B2);
    end else begin
      wr_d  = 4'b1000;
      off_d = a - ADDR_W'(B3);
    end
    if (!(accept && in_range)) wr_d = '0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    err_d    = err_q;
    ok_d     = load_ok;
    lerr_d   = load_err;
    if (dl_rise) begin
      state_d = LOAD;
      cnt_d   = '0;
      err_d   = 1'b0;
      ok_d    = 1'b0;
      lerr_d  = 1'b0;
    end
    if (accept) begin
      if (!in_range)                 err_d = 1'b1;
      else if (cnt_d != CW'(TOTAL))  cnt_d = cnt_d + CW'(1);
    end
    if (!dl_rise) begin
      case (state_q)
        LOAD: if (dl_fall) begin
          if (!err_q && cnt_q == CW'(TOTAL)) begin
            state_d  = SETTLE;
            settle_d = SW'(SETTLE_CYC);
          end else begin
            state_d = IDLE;
            lerr_d  = 1'b1;
            ok_d    = 1'b0;
          end
        end
        SETTLE: begin
          // A held user_reset keeps reloading, so release is measured from its fall.
          if (user_reset) begin
            settle_d = SW'(SETTLE_CYC);
          end else if (settle_q == SW'(1)) begin
            state_d = RUN;
            ok_d    = 1'b1;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end
        RUN: if (user_reset) begin
          state_d  = SETTLE;
          settle_d = SW'(SETTLE_CYC);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // dl_q resets high so a window already open across reset is not mistaken
  // for a new one; the host must reopen it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q       <= 1'b1;
      cnt_q      <= '0;
      settle_q   <= '0;
      err_q      <= 1'b0;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
      core_reset <= 1'b1;
      rom_wr     <= '0;
      rom_addr   <= '0;
      rom_data   <= '0;
    end else begin
      dl_q       <= dn_download;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      err_q      <= err_d;
      load_ok    <= ok_d;
      load_err   <= lerr_d;
      core_reset <= (state_d != RUN);
      rom_wr     <= wr_d;
      if (wr_d != 4'b0000) begin
        rom_addr <= off_d;
        rom_data <= dn_data;
      end
    end
  end

endmodule

// File: doc/rom_load_sequencer.md
# rom_load_sequencer

Download-and-reset sequencer between the HPS download port and the arcade core's ROM/RAM banks. It decodes the linear download stream into four ROM regions with per-region write strobes and region-relative addresses. It holds the core in reset from power-up until a complete, correctly sized image has been loaded and a settle period has elapsed. It also stretches user reset requests to a guaranteed minimum length.

## Interface

Parameters:
- ADDR_W, 17: width of the region-relative address output and of the decoded download address.
- B1, 'h0A000: first byte address of region 1. Region 0 is [0, B1).
- B2, 'h0C000: first byte address of region 2.
- B3, 'h10000: first byte address of region 3. Region 3 is [B3, TOTAL).
- TOTAL, 'h1C000: exact image size in bytes. Constraint: B1 < B2 < B3 < TOTAL ≤ 2^ADDR_W.
- SETTLE_CYC, 256: reset hold length in clocks, ≥ 1.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- dn_download  in  1  download window active.
- dn_wr  in  1  byte write strobe, one clk_sys cycle per byte.
- dn_addr  in  25  absolute byte address.
- dn_data  in  8  byte data.
- user_reset  in  1  active-high reset request (OSD/button), level.
- rom_wr  out  4  one-hot region write strobe.
- rom_addr  out  ADDR_W  address relative to the region base.
- rom_data  out  8  write data.
- core_reset  out  1  active-high reset to the core.
- busy  out  1  high in LOAD or SETTLE.
- load_ok  out  1  a valid image is resident.
- load_err  out  1  sticky: the last download failed.

## Operation

- States: IDLE, LOAD, SETTLE, RUN.
- Reset values (reset_n low): state=IDLE, rom_wr=0, rom_addr=0, rom_data=0, core_reset=1, busy=0, load_ok=0, load_err=0, byte counter=0, settle counter=0.
- IDLE: core_reset=1. A dn_download rise (registered previous value 0, current value 1) moves to LOAD.
- Any state: a dn_download rise enters LOAD, clears load_ok, load_err and the byte counter, and asserts core_reset.
- Write acceptance: a byte is processed when dn_wr=1 and dn_download=1 at the same sample. The sample is taken on the raw input, so a write coincident with the rising edge is accepted. Writes with dn_download=0 are ignored.
- Region decode on dn_addr[ADDR_W-1:0]:
  - a < B1 gives region 0, offset a.
  - a < B2 gives region 1, offset a−B1.
  - a < B3 gives region 2, offset a−B2.
  - a < TOTAL gives region 3, offset a−B3.
- Out-of-range write: dn_addr ≥ TOTAL (compared across the full 25 bits) sets the internal error flag and suppresses rom_wr.
- Byte counter: width ADDR_W+1, counts accepted in-range writes, saturates at TOTAL.
- LOAD exit on dn_download fall:
  - If the error flag is clear and count == TOTAL: go to SETTLE and load the settle counter with SETTLE_CYC.
  - Otherwise: go to IDLE with load_err=1 and load_ok=0.
- SETTLE: core_reset=1. The counter decrements each clock. When it reaches 1, the next state is RUN with load_ok=1.
- RUN: core_reset=0. user_reset=1 reloads the settle counter and enters SETTLE; load_ok stays 1.
- Repeated SETTLE re-entry: user_reset held high in SETTLE reloads the counter every cycle. Reset therefore lasts SETTLE_CYC clocks after user_reset falls.
- busy = (state==LOAD) | (state==SETTLE).

## Timing

- rom_wr, rom_addr and rom_data are registered: one-cycle latency from the dn_wr sample. rom_wr is a single-cycle pulse per byte. Back-to-back dn_wr gives back-to-back pulses.
- rom_addr and rom_data hold their last values between strobes.
- core_reset is registered: it rises one cycle after the dn_download rise is sampled.
- SETTLE lasts exactly SETTLE_CYC cycles. core_reset falls on the first RUN cycle.
- From the user_reset sample in RUN, core_reset rises one cycle later.
- An asynchronous reset_n assertion mid-LOAD aborts the load and returns to the reset values. No rom_wr is emitted after reset_n goes low.

## Test plan

- Power-up with no download: core_reset=1, load_ok=0, rom_wr=0 for 10 000 cycles.
- Full download of 'h1C000 bytes (dn_data = addr[7:0]):
  - Address 'h0A000 gives rom_wr=4'b0010, rom_addr=0.
  - Address 'h1BFFF gives rom_wr=4'b1000, rom_addr='hBFFF.
  - After dn_download falls, core_reset stays 1 for exactly 256 cycles, then 0 with load_ok=1.
- Short download of 'h1BFFF bytes: state returns to IDLE, load_err=1, load_ok=0, core_reset=1.
- Write at dn_addr='h1C000: no rom_wr pulse, load_err=1 at the end of the window.
- In RUN, user_reset high for 5 cycles: core_reset rises 1 cycle after user_reset is sampled. It falls 256 cycles after user_reset falls. load_ok stays 1.
- reset_n pulsed low mid-LOAD: all outputs return to reset values. Subsequent writes are ignored until a new dn_download rise.
